// File: rtl/master_out_port_if.sv
// Master-to-slave serial bus: request handshake, serial address/data lines and
// the latched transaction attributes the slave needs to follow a burst.
interface master_out_port_if;
  logic        master_valid;
  logic        slave_ready;
  logic        tx_addr;
  logic        tx_data;
  logic [12:0] burst;
  logic        write_en;
  logic        read_en;

  modport master (
    output master_valid, tx_addr, tx_data, burst, write_en, read_en,
    input  slave_ready
  );

  modport slave (
    input  master_valid, tx_addr, tx_data, burst, write_en, read_en,
    output slave_ready
  );
endinterface

// File: rtl/master_out_port.sv
// Serializer from the master core onto the system bus: handshake, then shift
// address/data LSB first; write bursts re-handshake and fetch one byte per beat.
module master_out_port (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [11:0]       addr_in,
  input  logic [7:0]        data_in,
  input  logic [11:0]       burst_len,
  output logic              data_next,
  output logic              busy,
  output logic              done,
  master_out_port_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, HS, SEND, FETCH, BHS, BSEND, FIN
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        write_q, write_d;
  logic [11:0] beats_q, beats_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        valid_q, valid_d;
  logic        tx_addr_q, tx_addr_d;
  logic        tx_data_q, tx_data_d;
  logic [12:0] burst_q, burst_d;
  logic        write_en_q, write_en_d;
  logic        read_en_q, read_en_d;
  logic        data_next_q, data_next_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // NOTE: every register below takes its value from the *_d network with <=,
  // so all flops update together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      beats_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      tx_addr_q   <= 1'b0;
      tx_data_q   <= 1'b0;
      burst_q     <= '0;
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      data_next_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      write_q     <= write_d;
      beats_q     <= beats_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
      burst_q     <= burst_d;
      write_en_q  <= write_en_d;
      read_en_q   <= read_en_d;
      data_next_q <= data_next_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default for state, zero-by-default for pulses; every
    // variable is assigned before the case so no path can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    write_d     = write_q;
    beats_d     = beats_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    tx_addr_d   = tx_addr_q;
    tx_data_d   = tx_data_q;
    burst_d     = burst_q;
    write_en_d  = write_en_q;
    read_en_d   = read_en_q;
    busy_d      = busy_q;
    data_next_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d     = addr_in;
          data_d     = data_in;
          write_d    = write;
          beats_d    = burst_len;
          burst_d    = {burst_len, (burst_len != 12'd0)};
          busy_d     = 1'b1;
          write_en_d = write;
          read_en_d  = !write;
          valid_d    = 1'b1;
          state_d    = HS;
        end
      end

      HS: begin
        if (bus.slave_ready) begin
          valid_d   = 1'b0;
          tx_addr_d = addr_q[0];
          tx_data_d = write_q & data_q[0];
          cnt_d     = 4'd1;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (cnt_q == 4'd12) begin
          tx_addr_d = 1'b0;
          tx_data_d = 1'b0;
          if (write_q && (beats_q != 12'd0)) begin
            data_next_d = 1'b1;
            state_d     = FETCH;
          end else begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            write_en_d = 1'b0;
            read_en_d  = 1'b0;
            state_d    = FIN;
          end
        end else begin
          tx_addr_d = addr_q[cnt_q];
          tx_data_d = (write_q && (cnt_q < 4'd8)) ? data_q[cnt_q[2:0]] : 1'b0;
          cnt_d     = cnt_q + 4'd1;
        end
      end

      FETCH: begin
        data_d  = data_in;
        valid_d = 1'b1;
        state_d = BHS;
      end

      BHS: begin
        if (bus.slave_ready) begin
          valid_d   = 1'b0;
          tx_data_d = data_q[0];
          cnt_d     = 4'd1;
          state_d   = BSEND;
        end
      end

      BSEND: begin
        if (cnt_q == 4'd8) begin
          // The slave advances the address itself, so only data moves per beat.
          tx_data_d = 1'b0;
          beats_d   = beats_q - 12'd1;
          if (beats_q != 12'd1) begin
            data_next_d = 1'b1;
            state_d     = FETCH;
          end else begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            write_en_d = 1'b0;
            read_en_d  = 1'b0;
            state_d    = FIN;
          end
        end else begin
          tx_data_d = data_q[cnt_q[2:0]];
          cnt_d     = cnt_q + 4'd1;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.master_valid = valid_q;
  assign bus.tx_addr      = tx_addr_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.burst        = burst_q;
  assign bus.write_en     = write_en_q;
  assign bus.read_en      = read_en_q;
  assign data_next        = data_next_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_master_out_port.sv
// Bench for master_out_port: builds the expected per-cycle bus timeline of each
// transaction from its parameters and compares the DUT against it every cycle.
module tb_master_out_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        write;
  logic [11:0] addr_in;
  logic [7:0]  data_in;
  logic [11:0] burst_len;
  logic        data_next;
  logic        busy;
  logic        done;

  master_out_port_if bus ();

  master_out_port dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .write     (write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .burst_len (burst_len),
    .data_next (data_next),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mv;
    logic ta;
    logic td;
    logic dn;
    logic busy;
    logic done;
    logic we;
    logic re;
  } obs_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  obs_t        exp_q[$];
  logic        rdy_q[$];
  logic [7:0]  bytes[$];
  logic [11:0] cur_addr;

  task automatic check_obs(input string tag, input int k, input obs_t exp_v);
    obs_t obs;
    obs.mv   = bus.master_valid;
    obs.ta   = bus.tx_addr;
    obs.td   = bus.tx_data;
    obs.dn   = data_next;
    obs.busy = busy;
    obs.done = done;
    obs.we   = bus.write_en;
    obs.re   = bus.read_en;
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed {mv,ta,td,dn,busy,done,we,re}=%b expected=%b",
             tag, k, obs, exp_v);
    end
  endtask

  task automatic check_burst(input string tag, input logic [12:0] exp_v);
    n_tests++;
    assert (bus.burst === exp_v) else begin
      n_fail++;
      $error("FAIL %s burst observed=%h expected=%h", tag, bus.burst, exp_v);
    end
  endtask

  // One handshake window: valid for st stall cycles plus the accepting cycle.
  task automatic add_window(input obs_t base, input int st);
    obs_t e;
    for (int i = 0; i <= st; i++) begin
      e    = base;
      e.mv = 1'b1;
      exp_q.push_back(e);
      rdy_q.push_back(i == st);
    end
  endtask

  task automatic build(input logic wr, input logic [11:0] bl, input int st0, input int stb);
    obs_t base, e;
    exp_q.delete();
    rdy_q.delete();
    base      = '0;
    base.busy = 1'b1;
    base.we   = wr;
    base.re   = !wr;
    add_window(base, st0);
    for (int i = 0; i < 12; i++) begin
      e    = base;
      e.ta = cur_addr[i];
      e.td = (wr && i < 8) ? bytes[0][i] : 1'b0;
      exp_q.push_back(e);
      rdy_q.push_back(1'($urandom));
    end
    if (wr) begin
      for (int b = 1; b <= int'(bl); b++) begin
        e    = base;
        e.dn = 1'b1;
        exp_q.push_back(e);
        rdy_q.push_back(1'($urandom));
        add_window(base, stb);
        for (int i = 0; i < 8; i++) begin
          e    = base;
          e.td = bytes[b][i];
          exp_q.push_back(e);
          rdy_q.push_back(1'($urandom));
        end
      end
    end
    e      = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
    rdy_q.push_back(1'($urandom));
  endtask

  // Drives one transaction and checks every cycle; stop_at >= 0 returns early
  // right after checking that cycle (used to abort a transfer with reset).
  task automatic run_txn(input logic wr, input logic [11:0] a, input logic [11:0] bl,
                         input int st0, input int stb, input int stop_at);
    int nb;
    nb       = 0;
    cur_addr = a;
    build(wr, bl, st0, stb);
    @(negedge clk);
    req             = 1'b1;
    write           = wr;
    addr_in         = a;
    data_in         = bytes[0];
    burst_len       = bl;
    bus.slave_ready = 1'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check_obs("cycle", k, exp_q[k]);
      check_burst("txn", {bl, (bl != 12'd0)});
      if (k == stop_at) return;
      req             = 1'($urandom);
      write           = 1'($urandom);
      addr_in         = 12'($urandom);
      burst_len       = 12'($urandom);
      bus.slave_ready = rdy_q[k];
      if (exp_q[k].dn) begin
        nb++;
        data_in = bytes[nb];
      end else begin
        data_in = 8'($urandom);
      end
    end
    req = 1'b0;
    @(negedge clk);
    check_obs("idle", 0, '0);
  endtask

  logic        rw;
  logic [11:0] rbl;

  initial begin
    reset           = 1'b0;
    req             = 1'b0;
    write           = 1'b0;
    addr_in         = '0;
    data_in         = '0;
    burst_len       = '0;
    bus.slave_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_obs("reset", 0, '0);
    check_burst("reset", 13'h0);
    reset = 1'b1;

    bytes = '{8'h3B};
    run_txn(1'b1, 12'hA5C, 12'd0, 0, 0, -1);

    bytes = '{8'h00};
    run_txn(1'b0, 12'h001, 12'd0, 0, 0, -1);

    bytes = '{8'($urandom)};
    run_txn(1'b1, 12'($urandom), 12'd0, 5, 0, -1);

    bytes = '{8'h3B, 8'h81, 8'hFF};
    run_txn(1'b1, 12'h7E1, 12'd2, 0, 3, -1);

    // Abort while addr bit 6 is on the line, then a fresh transfer must work.
    bytes = '{8'hC6};
    run_txn(1'b1, 12'h5A3, 12'd0, 0, 0, 7);
    reset = 1'b0;
    req   = 1'b0;
    #1;
    check_obs("rst_mid", 0, '0);
    check_burst("rst_mid", 13'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_obs("post_rst", k, '0);
    end
    bytes = '{8'h96};
    run_txn(1'b1, 12'h3C5, 12'd0, 1, 0, -1);

    for (int t = 0; t < 6; t++) begin
      rw  = 1'($urandom);
      rbl = rw ? 12'($urandom_range(3, 0)) : 12'($urandom);
      bytes.delete();
      for (int i = 0; i < 4; i++) bytes.push_back(8'($urandom));
      run_txn(rw, 12'($urandom), rbl, $urandom_range(3, 0), $urandom_range(3, 0), -1);
    end

    bytes = '{8'h5A};
    run_txn(1'b0, 12'hFFF, 12'd4095, 2, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/master_out_port.md
# master_out_port

Master-side serializer that feeds `slave_in_port` over the system bus. It accepts a parallel request from the master core: 12-bit address, 8-bit write data, read/write mode and burst length. It handshakes with the slave through `master_valid`/`slave_ready`, then shifts the address onto `tx_addr` and the data onto `tx_data`, LSB first, one bit per clock. Write bursts are handled by re-handshaking once per extra beat and fetching the next data byte from the core.

## Interface
- No parameters; widths are fixed: address 12, data 8, burst count 12.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: start request; sampled only in IDLE.
- `write` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr_in` in 12: transaction start address; sampled with `req`.
- `data_in` in 8: write data; sampled with `req`, then once per extra beat, one cycle after `data_next`.
- `burst_len` in 12: number of extra beats; 0 = single transfer.
- `slave_ready` in 1: slave can accept a handshake.
- `master_valid` out 1: request handshake. Handshake occurs at an edge where `master_valid & slave_ready` = 1.
- `tx_addr` out 1: serial address line.
- `tx_data` out 1: serial data line.
- `burst` out 13: {`burst_len` latched, (`burst_len` != 0)}.
- `write_en`, `read_en` out 1: latched mode, held for the whole transaction.
- `data_next` out 1: one-cycle pulse requesting the next burst byte.
- `busy` out 1: high from acceptance of `req` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation
- Reset (async, `reset`=0): every output is 0 and state is IDLE. This applies mid-transfer too; a partial transfer is abandoned with no `done`.
- States and transitions:
  - IDLE: on `req`=1, latch `addr_in`/`data_in`/`write`/`burst_len`. Set `busy`, `write_en`/`read_en` and `master_valid` to 1, then go to HS.
  - HS: hold `master_valid` until a handshake. At the handshake edge: `master_valid`<=0, `tx_addr`<=addr[0], `tx_data`<=(write ? data[0] : 0), bit counter<=1. Go to SEND.
  - SEND: at each edge, drive addr[cnt] on `tx_addr` and data[cnt] on `tx_data` (data only for cnt<8 and write; otherwise 0). Counter increments.
  - Leaving SEND: after addr[11] has been on the line for one cycle, go to FETCH if write and extra beats remain; otherwise go to FIN.
  - FETCH: `data_next`=1 for one cycle. At the next edge, latch `data_in`, set `master_valid`<=1 and go to BHS.
  - BHS: at the handshake edge, `master_valid`<=0 and `tx_data`<=data[0]. Go to BSEND.
  - BSEND: drive data bits 1..7 on successive cycles. After bit 7 has been on the line for one cycle, decrement the beat counter, then go to FETCH if beats remain, else FIN. `tx_addr` stays 0; the slave increments the address itself.
  - FIN: `done`=1 for one cycle. `busy`, `write_en`, `read_en`, `tx_*` and `master_valid` go to 0. Return to IDLE.
- Reads never enter FETCH. `burst` is forwarded and the slave handles read incrementing.
- `req` outside IDLE is ignored.
- Input changes after latching have no effect, except `data_in` at the FETCH edge.
- `slave_ready` low holds HS/BHS indefinitely; there is no timeout.
- `burst_len`=4095: the beat counter is 12 bits and counts down to 0 with no wrap.

## Timing
- Edge E0 samples `req`; `master_valid` is high after E0.
- With `slave_ready`=1, the handshake is at E1. `tx_addr` carries addr[i] during the cycle after E(1+i), for i=0..11. `tx_data` carries data[i] in the same cycles, for i=0..7.
- Single transfer: `done` is high in the cycle after E13. Minimum latency from `req` to `done` is 14 cycles.
- Burst beat: `data_next` is high after E13. `data_in` is latched at E14 and `master_valid` is high after E14. With the handshake at edge H, data[i] is on the line during the cycle after H+i.
- Each additional cycle of `slave_ready`=0 in HS/BHS adds exactly one cycle.
- `master_valid` is never high in the same cycle as a serial bit.

## Test plan
- Single write: `addr_in`=0xA5C, `data_in`=0x3B, `slave_ready`=1.
  - `tx_addr` = 0,0,1,1,1,0,1,0,0,1,0,1.
  - `tx_data` = 1,1,0,1,1,1,0,0, then 0 for the remaining four address cycles.
  - `done` 14 cycles after `req`; `burst`=0.
- Single read: `addr_in`=0x001.
  - `tx_addr` = 1 then eleven 0s; `tx_data` stays 0; `read_en`=1 and `write_en`=0 throughout; no `data_next`.
- Delayed slave: `slave_ready` held 0 for 5 cycles after `req`.
  - `master_valid` held for 6 cycles; serial stream shifted by 5; `done` at cycle 19.
- Write burst: `burst_len`=2, bytes 0x3B, 0x81, 0xFF; `slave_ready` drops for 3 cycles after each beat.
  - Exactly two `data_next` pulses and three handshakes.
  - Beat streams: 0x81 → 1,0,0,0,0,0,0,1; 0xFF → all 1s.
  - `burst`=0x005; one `done`.
- Reset mid-SEND: `reset`=0 during addr bit 6.
  - All outputs 0 immediately, no `done`; a new `req` afterwards completes normally.
- `req` asserted while busy (during BSEND): ignored, with no change to latched address or data; the next `req` after `done` is accepted.
